uart_cmd_rx: RTL and testbench

UART_CMD_RX -- requirements
Module: uart_cmd_rx

---
 rtl/uart_cmd_pkg.sv | 33 +++
 rtl/uart_rx_byte.sv | 119 +++++++++++
 rtl/uart_cmd_rx.sv | 131 +++++++++++++
 tb/tb_uart_cmd_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command receiver: the command byte codes
// understood by the decoder and the state encodings of the byte receiver and
// the command decoder FSM.
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

    // Command codes recognised while the decoder is idle
    localparam logic [7:0] CMD_CORE_RUN  = 8'h10;
    localparam logic [7:0] CMD_CORE_HALT = 8'h11;
    localparam logic [7:0] CMD_WRITE     = 8'h30;

    // Command decoder states, one step per received byte
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR0 = 3'd1,
        ST_ADDR1 = 3'd2,
        ST_DATA0 = 3'd3,
        ST_DATA1 = 3'd4,
        ST_DATA2 = 3'd5,
        ST_DATA3 = 3'd6
    } cmd_state_t;

    // Bit-level receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver with an input synchronizer, start-bit glitch
// rejection and stop-bit framing check.
//
// Ports:
//   clk          system clock, rising edge
//   arstn        asynchronous active-low reset
//   uart_rx      asynchronous serial input, idle high, LSB first
//   o_byte       last received byte (valid while o_byte_valid is high)
//   o_byte_valid one-cycle pulse at the stop-bit sample of a good byte
//   o_frame_err  one-cycle pulse when the stop bit is sampled low
// ---------------------------------------------------------------------------
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 260
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       uart_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic             w_startEdge;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    // All three reset to the idle-line level so reset never looks like a start.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_startEdge = r_prev & ~r_sync2;
    assign o_byte      = r_shift;

    // Receiver FSM. The start bit is re-checked at half a bit time so every
    // later sample lands mid-bit; the counter is always reloaded explicitly
    // at its terminal value and never wraps on its own.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state      <= RX_IDLE;
            r_cnt        <= '0;
            r_bitIdx     <= 3'd0;
            r_shift      <= 8'h00;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (w_startEdge) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt    <= '0;
                        r_bitIdx <= 3'd0;
                        // A line that is high again was only a glitch
                        r_state  <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bitIdx == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_sync2) begin
                            o_byte_valid <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx
// UART command receiver: decodes a byte stream into CPU core reset control
// and program-memory writes.
//   0x10           release the core (core_rstn = 1)
//   0x11           hold the core in reset (core_rstn = 0)
//   0x30 A0 A1 D0 D1 D2 D3
//                  write little-endian word D3..D0 to address A1:A0
//
// Ports:
//   clk        system clock, rising edge
//   arstn      asynchronous active-low reset
//   uart_rx    asynchronous serial input (8N1, idle high)
//   core_rstn  active-low reset to the CPU core
//   mem_we     one-cycle program-memory write strobe
//   mem_addr   program-memory word address (held until the next write)
//   mem_wdata  program-memory write data (held until the next write)
//   frame_err  one-cycle pulse on a byte whose stop bit was low
// ---------------------------------------------------------------------------
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 260,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        uart_rx,
    output logic        core_rstn,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        frame_err
);

    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = (TO_LIMIT > 1) ? $clog2(TO_LIMIT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

    logic [7:0]  w_byte;
    logic        w_byteValid;
    logic        w_frameErr;
    cmd_state_t  r_state;
    logic [15:0] r_addr;
    logic [23:0] r_data;
    logic [TO_W-1:0] r_toCnt;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .arstn        (arstn),
        .uart_rx      (uart_rx),
        .o_byte       (w_byte),
        .o_byte_valid (w_byteValid),
        .o_frame_err  (w_frameErr)
    );

    assign frame_err = w_frameErr;

    // Command decoder. Address and data are collected in shadow registers and
    // copied to the outputs only when the last data byte arrives, so aborted
    // commands never disturb mem_addr/mem_wdata.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state   <= ST_IDLE;
            r_addr    <= 16'h0000;
            r_data    <= 24'h000000;
            r_toCnt   <= '0;
            core_rstn <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 32'h0000_0000;
        end else begin
            mem_we <= 1'b0;

            // Idle-time counter, only meaningful while a command is open
            if (r_state == ST_IDLE || w_byteValid) begin
                r_toCnt <= '0;
            end else begin
                r_toCnt <= r_toCnt + 1'b1;
            end

            if (w_frameErr) begin
                r_state <= ST_IDLE;
            end else if (r_state != ST_IDLE && r_toCnt == TO_LAST && !w_byteValid) begin
                r_state <= ST_IDLE;
            end else if (w_byteValid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_byte == CMD_CORE_RUN) begin
                            core_rstn <= 1'b1;
                        end else if (w_byte == CMD_CORE_HALT) begin
                            core_rstn <= 1'b0;
                        end else if (w_byte == CMD_WRITE) begin
                            r_state <= ST_ADDR0;
                        end
                    end
                    ST_ADDR0: begin
                        r_addr[7:0] <= w_byte;
                        r_state     <= ST_ADDR1;
                    end
                    ST_ADDR1: begin
                        r_addr[15:8] <= w_byte;
                        r_state      <= ST_DATA0;
                    end
                    ST_DATA0: begin
                        r_data[7:0] <= w_byte;
                        r_state     <= ST_DATA1;
                    end
                    ST_DATA1: begin
                        r_data[15:8] <= w_byte;
                        r_state      <= ST_DATA2;
                    end
                    ST_DATA2: begin
                        r_data[23:16] <= w_byte;
                        r_state       <= ST_DATA3;
                    end
                    ST_DATA3: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_addr;
                        mem_wdata <= {w_byte, r_data};
                        r_state   <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_rx
// Directed self-checking bench for uart_cmd_rx, using a short bit time so
// whole command sequences run quickly.
// ---------------------------------------------------------------------------
module tb_uart_cmd_rx;

    localparam int CPB = 16;
    localparam int TOB = 40;

    logic        clk = 1'b0;
    logic        arstn;
    logic        uart_rx;
    logic        core_rstn;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        frame_err;

    int          checks   = 0;
    int          failures = 0;
    int          weCount  = 0;
    int          feCount  = 0;
    logic [15:0] capAddr  = 16'h0000;
    logic [31:0] capData  = 32'h0;

    always #5 clk = ~clk;

    uart_cmd_rx #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .uart_rx   (uart_rx),
        .core_rstn (core_rstn),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .frame_err (frame_err)
    );

    // Pulse monitor: counts strobe cycles and captures the write fields
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            weCount = weCount + 1;
            capAddr = mem_addr;
            capData = mem_wdata;
        end
        if (frame_err === 1'b1) begin
            feCount = feCount + 1;
        end
    end

    // Start bit plus eight data bits, LSB first
    task automatic sendBits(input logic [7:0] b);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stopVal);
        sendBits(b);
        uart_rx = stopVal;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic idleBits(input int n);
        uart_rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic test_reset;
        arstn   = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (core_rstn !== 1'b0)     begin failures++; $display("[TB] FAIL reset_core_rstn got=%b exp=0", core_rstn); end
        checks++; if (mem_we !== 1'b0)        begin failures++; $display("[TB] FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 16'h0)     begin failures++; $display("[TB] FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
        checks++; if (mem_wdata !== 32'h0)    begin failures++; $display("[TB] FAIL reset_mem_wdata got=%h exp=00000000", mem_wdata); end
        checks++; if (frame_err !== 1'b0)     begin failures++; $display("[TB] FAIL reset_frame_err got=%b exp=0", frame_err); end
        arstn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_core_ctrl;
        // 0x10: core_rstn must still be low early in the stop bit and high by its end
        sendBits(8'h10);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (core_rstn !== 1'b0) begin failures++; $display("[TB] FAIL run_before_stop got=%b exp=0", core_rstn); end
        repeat (CPB - 4) @(negedge clk);
        checks++; if (core_rstn !== 1'b1) begin failures++; $display("[TB] FAIL run_after_stop got=%b exp=1", core_rstn); end
        repeat (2) @(negedge clk);
        sendByte(8'h11, 1'b1);
        checks++; if (core_rstn !== 1'b0) begin failures++; $display("[TB] FAIL halt got=%b exp=0", core_rstn); end
    endtask

    task automatic test_write_basic;
        logic [7:0] bytesA [7] = '{8'h30, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        weCount = 0;
        feCount = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                // Short low glitch between bytes must not be taken as a byte
                uart_rx = 1'b0;
                repeat (3) @(negedge clk);
                uart_rx = 1'b1;
                repeat (CPB) @(negedge clk);
            end
            sendByte(bytesA[i], 1'b1);
        end
        idleBits(1);
        checks++; if (weCount !== 1)               begin failures++; $display("[TB] FAIL basic_we_pulses got=%0d exp=1", weCount); end
        checks++; if (capAddr !== 16'h0201)        begin failures++; $display("[TB] FAIL basic_addr got=%h exp=0201", capAddr); end
        checks++; if (capData !== 32'h06050403)    begin failures++; $display("[TB] FAIL basic_data got=%h exp=06050403", capData); end
        checks++; if (mem_addr !== 16'h0201)       begin failures++; $display("[TB] FAIL basic_addr_held got=%h exp=0201", mem_addr); end
        checks++; if (mem_wdata !== 32'h06050403)  begin failures++; $display("[TB] FAIL basic_data_held got=%h exp=06050403", mem_wdata); end
        checks++; if (core_rstn !== 1'b0)          begin failures++; $display("[TB] FAIL basic_core_rstn got=%b exp=0", core_rstn); end
        checks++; if (feCount !== 0)               begin failures++; $display("[TB] FAIL basic_frame_err got=%0d exp=0", feCount); end
    endtask

    task automatic test_payload_codes;
        logic [7:0] bytesB [8] = '{8'h55, 8'h30, 8'h10, 8'h00, 8'h11, 8'h30, 8'h10, 8'h13};
        weCount = 0;
        for (int i = 0; i < 8; i++) begin
            sendByte(bytesB[i], 1'b1);
        end
        idleBits(1);
        checks++; if (weCount !== 1)            begin failures++; $display("[TB] FAIL payload_we_pulses got=%0d exp=1", weCount); end
        checks++; if (capAddr !== 16'h0010)     begin failures++; $display("[TB] FAIL payload_addr got=%h exp=0010", capAddr); end
        checks++; if (capData !== 32'h13103011) begin failures++; $display("[TB] FAIL payload_data got=%h exp=13103011", capData); end
        checks++; if (core_rstn !== 1'b0)       begin failures++; $display("[TB] FAIL payload_core_rstn got=%b exp=0", core_rstn); end
    endtask

    task automatic test_timeout;
        weCount = 0;
        sendByte(8'h30, 1'b1);
        sendByte(8'h05, 1'b1);
        sendByte(8'h00, 1'b1);
        idleBits(45);
        sendByte(8'h10, 1'b1);
        idleBits(1);
        checks++; if (weCount !== 0)      begin failures++; $display("[TB] FAIL timeout_we_pulses got=%0d exp=0", weCount); end
        checks++; if (core_rstn !== 1'b1) begin failures++; $display("[TB] FAIL timeout_core_rstn got=%b exp=1", core_rstn); end
        checks++; if (mem_addr !== 16'h0010) begin failures++; $display("[TB] FAIL timeout_addr_kept got=%h exp=0010", mem_addr); end
    endtask

    task automatic test_frame_abort;
        logic [7:0] bytesC [7] = '{8'h30, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        weCount = 0;
        feCount = 0;
        sendByte(8'h30, 1'b1);
        sendByte(8'h07, 1'b0);
        idleBits(1);
        checks++; if (feCount !== 1) begin failures++; $display("[TB] FAIL frame_err_pulses got=%0d exp=1", feCount); end
        checks++; if (weCount !== 0) begin failures++; $display("[TB] FAIL frame_abort_we got=%0d exp=0", weCount); end
        for (int i = 0; i < 7; i++) begin
            sendByte(bytesC[i], 1'b1);
        end
        idleBits(1);
        checks++; if (weCount !== 1)            begin failures++; $display("[TB] FAIL frame_next_we got=%0d exp=1", weCount); end
        checks++; if (capAddr !== 16'h0008)     begin failures++; $display("[TB] FAIL frame_next_addr got=%h exp=0008", capAddr); end
        checks++; if (capData !== 32'hDDCCBBAA) begin failures++; $display("[TB] FAIL frame_next_data got=%h exp=DDCCBBAA", capData); end
        checks++; if (feCount !== 1)            begin failures++; $display("[TB] FAIL frame_err_extra got=%0d exp=1", feCount); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] bytesD [7] = '{8'h30, 8'h34, 8'h12, 8'h78, 8'h56, 8'h34, 8'h12};
        sendByte(8'h10, 1'b1);
        sendByte(8'h30, 1'b1);
        sendByte(8'h01, 1'b1);
        sendByte(8'h02, 1'b1);
        sendByte(8'h03, 1'b1);
        // Partway through the next byte, pull reset
        uart_rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        arstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (core_rstn !== 1'b0)  begin failures++; $display("[TB] FAIL midrst_core_rstn got=%b exp=0", core_rstn); end
        checks++; if (mem_we !== 1'b0)     begin failures++; $display("[TB] FAIL midrst_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 16'h0)  begin failures++; $display("[TB] FAIL midrst_mem_addr got=%h exp=0000", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL midrst_mem_wdata got=%h exp=00000000", mem_wdata); end
        checks++; if (frame_err !== 1'b0)  begin failures++; $display("[TB] FAIL midrst_frame_err got=%b exp=0", frame_err); end
        uart_rx = 1'b1;
        arstn   = 1'b1;
        idleBits(2);
        weCount = 0;
        for (int i = 0; i < 7; i++) begin
            sendByte(bytesD[i], 1'b1);
        end
        idleBits(1);
        checks++; if (weCount !== 1)            begin failures++; $display("[TB] FAIL midrst_next_we got=%0d exp=1", weCount); end
        checks++; if (capAddr !== 16'h1234)     begin failures++; $display("[TB] FAIL midrst_next_addr got=%h exp=1234", capAddr); end
        checks++; if (capData !== 32'h12345678) begin failures++; $display("[TB] FAIL midrst_next_data got=%h exp=12345678", capData); end
        checks++; if (core_rstn !== 1'b0)       begin failures++; $display("[TB] FAIL midrst_next_core got=%b exp=0", core_rstn); end
    endtask

    initial begin
        arstn   = 1'b0;
        uart_rx = 1'b1;
        test_reset();
        test_core_ctrl();
        test_write_basic();
        test_payload_codes();
        test_timeout();
        test_frame_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
